muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit downstream of the multicycle controller's execute stage. Accepts an M-extension operation (func3 plus two register operands) on a one-cycle `start` pulse and computes it over XLEN iterations. Returns a 32-bit result with a one-cycle `done` pulse; the controller holds its execute state until `done`, then proceeds to ALU writeback.

## Interface
- XLEN, 32: operand/result width; also the iteration count.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only when unit is idle or in DONE.
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand; sampled with start.
- b  in  XLEN  rs2 operand; sampled with start.
- busy  out  1  high while an operation is in flight (ITER, FIX).
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  registered result; held until the next accepted start.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE: on start, latch func3, the sign flags and operand magnitudes.
  - Magnitude is taken as the absolute value only for signed operands: a for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
  - Clear the 2·XLEN accumulator and the iteration counter, then go to ITER.
- Special cases bypass ITER; on start, go straight to DONE with result loaded:
  - Divide by zero (b==0, func3[2]=1): DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- ITER, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2·XLEN unsigned product.
- ITER, divide: restoring division, one quotient bit per cycle, MSB first.
  - The remainder register is XLEN+1 bits so the trial subtract does not overflow.
- ITER exits to FIX when the counter reaches XLEN-1.
- FIX: apply signs, select the output word, register `result`, go to DONE.
  - Multiply: negate the 64-bit product if the operand signs differ. MUL takes the low word; MULH, MULHSU and MULHU take the high word.
  - DIV: negate the quotient if the operand signs differ.
  - REM: the remainder takes the sign of a.
  - All arithmetic is modulo 2^XLEN or 2^(2·XLEN); no traps.
- DONE: done=1 for exactly one cycle.
  - If start is high in DONE, accept the new request (same rules as IDLE); otherwise go to IDLE.
- start while busy is ignored; the latched operands are unaffected.
- func3/a/b changing after the accepting edge have no effect.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, result=0, counter=0, accumulators=0.
- Reset mid-operation aborts; no done is produced.
- Normal latency: start sampled at edge T.
  - busy is high from after T through the FIX cycle.
  - ITER lasts XLEN cycles, then FIX lasts 1 cycle.
  - done is high in the cycle after edge T+XLEN+1, i.e. XLEN+2 cycles after start (34 for XLEN=32).
- Special-case latency: done high the cycle after edge T (1 cycle); busy stays 0.
- Back-to-back: start asserted during done is accepted; no idle bubble.
- busy and done are never high together.
- result changes only on the FIX edge or the special-case edge.

## Test plan
- MUL a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; done exactly 34 cycles after start; busy high 33 cycles.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3); REM a=-7, b=2 -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5, each with done 1 cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, 1 cycle.
- Second start pulsed while busy is ignored (result from the first op only); start during the done cycle is accepted with its done 34 cycles later.
- Deassert resetn at ITER cycle 10 -> busy=0, done=0, result=0 immediately; no done after release; next start completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// Accepts one M-extension operation per start pulse and computes it over
// XLEN iterations. Multiply is shift-add, and divide is restoring division.
// Divide-by-zero and signed overflow bypass the iterations and complete in
// one cycle.
//
// Ports:
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   start   in   request pulse, sampled in IDLE or DONE
//   func3   in   M-extension op: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   a, b    in   rs1 / rs2 operands, sampled with start
//   busy    out  operation in flight (ITER, FIX)
//   done    out  one-cycle pulse, result valid
//   result  out  registered result, held until the next accepted start
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t              state;
  logic [2:0]          op;
  logic                sa, sb;     // effective operand signs (0 for unsigned ops)
  logic [2*XLEN-1:0]   acc;        // product accumulator
  logic [2*XLEN-1:0]   mcand;      // multiplicand, shifted left each iteration
  logic [XLEN-1:0]     opb;        // multiplier (shifted right) or divisor
  logic [XLEN-1:0]     quo;        // dividend bits shift out MSB-first while quotient bits shift in
  logic [XLEN:0]       rem;
  logic [CW-1:0]       cnt;

  logic                accept, sgn_a, sgn_b, div_zero, div_ovf, special;
  logic [XLEN-1:0]     a_mag, b_mag, special_res, fix_res, q_s, r_s;
  logic [XLEN+1:0]     rem_sh, rem_diff;
  logic [2*XLEN-1:0]   prod;

  always_comb begin
    accept   = start && (state == IDLE || state == DONE);
    sgn_a    = (func3 == 3'b001) || (func3 == 3'b010) ||
               (func3 == 3'b100) || (func3 == 3'b110);
    sgn_b    = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    a_mag    = (sgn_a && a[XLEN-1]) ? -a : a;
    b_mag    = (sgn_b && b[XLEN-1]) ? -b : b;
    div_zero = func3[2] && (b == '0);
    div_ovf  = func3[2] && !func3[0] &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = func3[1] ? a : '1;
    else          special_res = func3[1] ? '0 : a;

    // Restoring step: shift next dividend bit into the remainder, trial subtract.
    rem_sh   = {rem, quo[XLEN-1]};
    rem_diff = rem_sh - {2'b00, opb};

    prod = (sa ^ sb) ? -acc : acc;
    q_s  = (sa ^ sb) ? -quo : quo;
    r_s  = sa ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    if (!op[2])     fix_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op[1]) fix_res = r_s;
    else            fix_res = q_s;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op    <= func3;
            sa    <= sgn_a && a[XLEN-1];
            sb    <= sgn_b && b[XLEN-1];
            acc   <= '0;
            cnt   <= '0;
            mcand <= {{XLEN{1'b0}}, a_mag};
            opb   <= b_mag;
            quo   <= a_mag;
            rem   <= '0;
            if (special) begin
              result <= special_res;
              state  <= DONE;
            end else begin
              state  <= ITER;
            end
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          if (op[2]) begin
            if (rem_sh >= {2'b00, opb}) begin
              rem <= rem_diff[XLEN:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= rem_sh[XLEN:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
          end else begin
            if (opb[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ITER) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        resetn, start;
  logic [2:0]  func3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  string       sb_name[$];
  bit          overlap = 1'b0;
  logic [31:0] col_exp;
  string       col_nm;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn), .start(start), .func3(func3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard collector: every done pops one expected result.
  always @(negedge clk) begin
    if (busy && done) overlap = 1'b1;
    if (resetn === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result 0x%08h, expected no done", result);
      end else begin
        col_exp = sb_q.pop_front();
        col_nm  = sb_name.pop_front();
        check({col_nm, "_result"}, result, col_exp);
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] exp);
    start = 1'b1;
    func3 = f;
    a     = aa;
    b     = bb;
    sb_q.push_back(exp);
    sb_name.push_back(name);
  endtask

  // Waits for done, checking latency and busy duration; optionally pulses a
  // second start while busy at cycle poke_k.
  task automatic wait_done(input string name, input int exp_lat, input int poke_k);
    int lat = 0;
    int busy_cnt = 0;
    bit got = 1'b0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        func3 = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
      end
      if (poke_k != 0 && k == poke_k) begin
        start = 1'b1;
        func3 = 3'b000;
        a     = 32'd3;
        b     = 32'd5;
      end
      if (poke_k != 0 && k == poke_k + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        lat = k;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done in 100 cycles, expected done at cycle %0d", name, exp_lat);
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy_cycles"}, 32'(busy_cnt), (exp_lat == 1) ? 32'd0 : 32'(exp_lat - 1));
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] exp, input int lat);
    @(negedge clk);
    issue(name, f, aa, bb, exp);
    wait_done(name, lat, 0);
  endtask

  initial begin
    vecs[0]  = '{"mul_7_m3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{"mulh_min_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{"mulhu_max_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{"mulhsu_m1_max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{"mulh_m7_3",       3'b001, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 34};
    vecs[5]  = '{"mulhu_min_4",     3'b011, 32'h80000000, 32'd4,        32'h00000002, 34};
    vecs[6]  = '{"div_m7_2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[7]  = '{"rem_m7_2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[8]  = '{"divu_100_7",      3'b101, 32'd100,      32'd7,        32'd14,       34};
    vecs[9]  = '{"remu_100_7",      3'b111, 32'd100,      32'd7,        32'd2,        34};
    vecs[10] = '{"div_7_m2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[11] = '{"rem_7_m2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
    vecs[12] = '{"div_min_2",       3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34};
    vecs[13] = '{"divu_max_1",      3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34};
    vecs[14] = '{"divu_5_0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[15] = '{"rem_5_0",         3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[16] = '{"div_ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[17] = '{"rem_ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

    resetn = 1'b0;
    start  = 1'b0;
    func3  = '0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Result is held after done while the inputs wander.
    repeat (3) @(negedge clk);
    check("result_hold", result, 32'd0);

    // start while busy is ignored.
    @(negedge clk);
    issue("busy_ignore", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    wait_done("busy_ignore", 34, 5);

    // Back-to-back: second start during the done cycle.
    @(negedge clk);
    issue("b2b_first", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    wait_done("b2b_first", 34, 0);
    issue("b2b_second", 3'b101, 32'd100, 32'd7, 32'd14);
    wait_done("b2b_second", 34, 0);

    // Special case followed back-to-back by a normal op.
    @(negedge clk);
    issue("b2b_special", 3'b111, 32'd9, 32'd0, 32'd9);
    wait_done("b2b_special", 1, 0);
    issue("b2b_after_special", 3'b111, 32'd9, 32'd4, 32'd1);
    wait_done("b2b_after_special", 34, 0);

    // Reset during ITER aborts the operation.
    @(negedge clk);
    issue("rst_abort", 3'b011, 32'hFFFFFFFF, 32'd2, 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy",   {31'b0, busy}, 32'd0);
    check("rst_mid_done",   {31'b0, done}, 32'd0);
    check("rst_mid_result", result,        32'd0);
    void'(sb_q.pop_front());
    void'(sb_name.pop_front());
    @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    check("rst_release_busy", {31'b0, busy}, 32'd0);
    run_op("after_reset", 3'b000, 32'd12345, 32'd1000, 32'd12345000, 34);

    repeat (3) @(negedge clk);
    check("busy_done_overlap", {31'b0, overlap}, 32'd0);
    check("scoreboard_empty",  32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
